// File: rtl/exec_unit_if.sv
// Handshake and operand bundle between the register file read side and exec_unit.
// Latency: pure wiring, no storage.
// Backpressure: the producer must hold off start while busy is high, or the request is dropped.
interface exec_unit_if #(
  parameter int WIDTH = 32
);
  // request side, driven by the issue logic
  logic             start;
  logic [3:0]       op;
  logic             is_branch;
  logic             use_imm;
  logic [WIDTH-1:0] Op_A;
  logic [WIDTH-1:0] Op_B;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] pc;
  logic [4:0]       rd_in;
  logic             wb_en_in;

  // completion side, driven by exec_unit toward the register file write port
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             branch_taken;
  logic [4:0]       rd_out;
  logic             write_en;

  modport master (
    output start, op, is_branch, use_imm, Op_A, Op_B, imm, pc, rd_in, wb_en_in,
    input  busy, done, result, branch_taken, rd_out, write_en
  );

  modport slave (
    input  start, op, is_branch, use_imm, Op_A, Op_B, imm, pc, rd_in, wb_en_in,
    output busy, done, result, branch_taken, rd_out, write_en
  );
endinterface

// File: rtl/exec_unit.sv
// RV32I execute stage: single-cycle ALU and branch ops, iterative 1-bit/cycle shifter.
// Latency: 1 cycle for ALU, branch and zero-amount shifts; 1+n cycles for a shift by n.
// Backpressure: busy is high while shifting; a start seen during busy is silently dropped.
module exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  exec_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // decode of the incoming request
  logic             accept;
  logic [WIDTH-1:0] b_sel;
  logic [4:0]       amt;
  logic             is_shift;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ok;
  logic             br_cond;

  // shifter state
  logic [WIDTH-1:0] sh_q;
  logic [4:0]       cnt_q;
  logic             sh_right_q;
  logic             sh_arith_q;
  logic [WIDTH-1:0] sh_step;
  logic             sh_last;

  // fields of the instruction in flight, used to qualify write_en
  logic [4:0]       rd_q;
  logic             wb_q;
  logic             br_q;
  logic             ok_q;

  // architecturally visible results, held until the next completion
  logic [WIDTH-1:0] result_q;
  logic             taken_q;
  logic [4:0]       rd_out_q;

  // Request decode: acceptance, operand select, ALU result and branch condition.
  always_comb begin
    accept   = 1'b0;
    b_sel    = '0;
    amt      = '0;
    is_shift = 1'b0;
    alu_res  = '0;
    alu_ok   = 1'b0;
    br_cond  = 1'b0;

    accept   = bus.start && (state != SHIFT);
    b_sel    = bus.use_imm ? bus.imm : bus.Op_B;
    amt      = b_sel[4:0];
    is_shift = !bus.is_branch &&
               ((bus.op == 4'b0001) || (bus.op == 4'b0101) || (bus.op == 4'b1101));

    unique case (bus.op)
      4'b0000: begin alu_res = bus.Op_A + b_sel; alu_ok = 1'b1; end
      4'b1000: begin alu_res = bus.Op_A - b_sel; alu_ok = 1'b1; end
      4'b0010: begin
        alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.Op_A) < $signed(b_sel))};
        alu_ok  = 1'b1;
      end
      4'b0011: begin alu_res = {{(WIDTH-1){1'b0}}, (bus.Op_A < b_sel)}; alu_ok = 1'b1; end
      4'b0100: begin alu_res = bus.Op_A ^ b_sel; alu_ok = 1'b1; end
      4'b0110: begin alu_res = bus.Op_A | b_sel; alu_ok = 1'b1; end
      4'b0111: begin alu_res = bus.Op_A & b_sel; alu_ok = 1'b1; end
      default: begin alu_res = '0; alu_ok = 1'b0; end
    endcase

    // branches always compare against the register operand, never the immediate
    unique case (bus.op[2:0])
      3'b000:  br_cond = (bus.Op_A == bus.Op_B);
      3'b001:  br_cond = (bus.Op_A != bus.Op_B);
      3'b100:  br_cond = ($signed(bus.Op_A) <  $signed(bus.Op_B));
      3'b101:  br_cond = ($signed(bus.Op_A) >= $signed(bus.Op_B));
      3'b110:  br_cond = (bus.Op_A <  bus.Op_B);
      3'b111:  br_cond = (bus.Op_A >= bus.Op_B);
      default: br_cond = 1'b0;
    endcase
  end

  // One-bit shift step of the value in flight; SRA replicates the sign bit.
  always_comb begin
    sh_step = '0;
    if (!sh_right_q) begin
      sh_step = {sh_q[WIDTH-2:0], 1'b0};
    end else if (sh_arith_q) begin
      sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    end else begin
      sh_step = {1'b0, sh_q[WIDTH-1:1]};
    end
    sh_last = (cnt_q == 5'd1);
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt    = state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.write_en = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = (is_shift && (amt != 5'd0)) ? SHIFT : DONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        bus.busy  = 1'b1;
        state_nxt = sh_last ? DONE : SHIFT;
      end
      default: state_nxt = IDLE;
    endcase

    if (state == DONE) begin
      bus.done     = 1'b1;
      bus.write_en = wb_q && ok_q && !br_q && (rd_q != 5'd0);
    end
  end

  // Datapath: capture on acceptance, iterate the shifter, publish results at completion.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sh_q       <= '0;
      cnt_q      <= '0;
      sh_right_q <= 1'b0;
      sh_arith_q <= 1'b0;
      rd_q       <= '0;
      wb_q       <= 1'b0;
      br_q       <= 1'b0;
      ok_q       <= 1'b0;
      result_q   <= '0;
      taken_q    <= 1'b0;
      rd_out_q   <= '0;
    end else if (accept) begin
      rd_q <= bus.rd_in;
      wb_q <= bus.wb_en_in;
      br_q <= bus.is_branch;
      ok_q <= is_shift || alu_ok;
      if (is_shift && (amt != 5'd0)) begin
        sh_q       <= bus.Op_A;
        cnt_q      <= amt;
        sh_right_q <= bus.op[2];
        sh_arith_q <= bus.op[3];
      end else begin
        // single-cycle ops complete in the next cycle, so publish now
        if (bus.is_branch) begin
          result_q <= bus.pc + bus.imm;
        end else if (is_shift) begin
          result_q <= bus.Op_A;
        end else begin
          result_q <= alu_res;
        end
        taken_q  <= bus.is_branch && br_cond;
        rd_out_q <= bus.rd_in;
      end
    end else if (state == SHIFT) begin
      sh_q  <= sh_step;
      cnt_q <= cnt_q - 5'd1;
      if (sh_last) begin
        result_q <= sh_step;
        taken_q  <= 1'b0;
        rd_out_q <= rd_q;
      end
    end
  end

  assign bus.result       = result_q;
  assign bus.branch_taken = taken_q;
  assign bus.rd_out       = rd_out_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit with hand-computed expectations.
// Latency: checks sample outputs 1 time unit after each rising edge.
// Backpressure: exercises a start issued while the shifter is busy.
module tb_exec_unit;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   pulses;

  exec_unit_if #(.WIDTH(32)) bus ();

  exec_unit #(.WIDTH(32)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic br, input logic ui,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] pc, input logic [4:0] rd, input logic wb);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.is_branch = br;
    bus.use_imm   = ui;
    bus.Op_A      = a;
    bus.Op_B      = b;
    bus.imm       = im;
    bus.pc        = pc;
    bus.rd_in     = rd;
    bus.wb_en_in  = wb;
  endtask

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.is_branch = 1'b0; bus.use_imm = 1'b0;
    bus.Op_A = '0; bus.Op_B = '0; bus.imm = '0; bus.pc = '0; bus.rd_in = '0; bus.wb_en_in = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_done",   {31'd0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_rd_out", {27'd0, bus.rd_out}, 32'd0);
    chk("rst_wen",    {31'd0, bus.write_en}, 32'd0);
    chk("rst_taken",  {31'd0, bus.branch_taken}, 32'd0);

    // SLL 1 by 31, aborted by reset partway through
    Rst = 1'b1;
    issue(4'b0001, 1'b0, 1'b0, 32'h1, 32'd31, 32'h0, 32'h0, 5'd3, 1'b1);
    tick();
    bus.start = 1'b0;
    chk("sll_busy", {31'd0, bus.busy}, 32'd1);
    tick(); tick(); tick();
    Rst = 1'b0;
    tick();
    chk("abort_busy",   {31'd0, bus.busy}, 32'd0);
    chk("abort_done",   {31'd0, bus.done}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_rd_out", {27'd0, bus.rd_out}, 32'd0);
    Rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done || bus.write_en) pulses++;
    end
    chk("abort_no_done", pulses, 32'd0);

    // ADD with signed overflow
    issue(4'b0000, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 5'd5, 1'b1);
    tick();
    bus.start = 1'b0;
    chk("add_done",   {31'd0, bus.done}, 32'd1);
    chk("add_wen",    {31'd0, bus.write_en}, 32'd1);
    chk("add_result", bus.result, 32'h80000000);
    chk("add_rd_out", {27'd0, bus.rd_out}, 32'd5);
    tick();
    chk("add_done_low", {31'd0, bus.done}, 32'd0);
    chk("add_wen_low",  {31'd0, bus.write_en}, 32'd0);
    chk("add_hold",     bus.result, 32'h80000000);

    // SUB 0 - 1 using the immediate as B; Op_B must be ignored
    issue(4'b1000, 1'b0, 1'b1, 32'h0, 32'h5, 32'h1, 32'h0, 5'd6, 1'b1);
    tick();
    bus.start = 1'b0;
    chk("sub_result", bus.result, 32'hFFFFFFFF);
    chk("sub_wen",    {31'd0, bus.write_en}, 32'd1);

    // SRA by 4 (B[31:5] ignored), with a start dropped while busy
    issue(4'b1101, 1'b0, 1'b0, 32'h80000000, 32'h00000024, 32'h0, 32'h0, 5'd7, 1'b1);
    tick();
    chk("sra_busy1", {31'd0, bus.busy}, 32'd1);
    chk("sra_hold",  bus.result, 32'hFFFFFFFF);
    issue(4'b0000, 1'b0, 1'b0, 32'h1, 32'h1, 32'h0, 32'h0, 5'd9, 1'b1);
    tick();
    bus.start = 1'b0;
    chk("sra_busy2", {31'd0, bus.busy}, 32'd1);
    chk("sra_nodone2", {31'd0, bus.done}, 32'd0);
    tick();
    chk("sra_busy3", {31'd0, bus.busy}, 32'd1);
    tick();
    chk("sra_busy4", {31'd0, bus.busy}, 32'd1);
    chk("sra_nodone4", {31'd0, bus.done}, 32'd0);
    tick();
    chk("sra_done",   {31'd0, bus.done}, 32'd1);
    chk("sra_busy5",  {31'd0, bus.busy}, 32'd0);
    chk("sra_result", bus.result, 32'hF8000000);
    chk("sra_rd_out", {27'd0, bus.rd_out}, 32'd7);
    chk("sra_wen",    {31'd0, bus.write_en}, 32'd1);
    tick();
    chk("dropped_no_done", {31'd0, bus.done}, 32'd0);
    chk("dropped_result",  bus.result, 32'hF8000000);

    // SLL by 0 (upper B bits set, amount field zero)
    issue(4'b0001, 1'b0, 1'b0, 32'h12345678, 32'hFFFFFFE0, 32'h0, 32'h0, 5'd4, 1'b1);
    tick();
    bus.start = 1'b0;
    chk("sll0_done",   {31'd0, bus.done}, 32'd1);
    chk("sll0_busy",   {31'd0, bus.busy}, 32'd0);
    chk("sll0_result", bus.result, 32'h12345678);

    // BLT then BLTU back to back, same operands; use_imm must not affect the compare
    issue(4'b0100, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFF0, 32'h100, 5'd8, 1'b1);
    tick();
    chk("blt_done",   {31'd0, bus.done}, 32'd1);
    chk("blt_taken",  {31'd0, bus.branch_taken}, 32'd1);
    chk("blt_target", bus.result, 32'h000000F0);
    chk("blt_wen",    {31'd0, bus.write_en}, 32'd0);
    bus.op = 4'b0110;
    tick();
    bus.start = 1'b0;
    chk("bltu_done",   {31'd0, bus.done}, 32'd1);
    chk("bltu_taken",  {31'd0, bus.branch_taken}, 32'd0);
    chk("bltu_target", bus.result, 32'h000000F0);

    // back-to-back ADD (rd=0), XOR, SLTU
    issue(4'b0000, 1'b0, 1'b0, 32'd3, 32'd4, 32'h0, 32'h0, 5'd0, 1'b1);
    tick();
    chk("b2b_add_done", {31'd0, bus.done}, 32'd1);
    chk("b2b_add_res",  bus.result, 32'd7);
    chk("b2b_add_wen",  {31'd0, bus.write_en}, 32'd0);
    issue(4'b0100, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 5'd10, 1'b1);
    tick();
    chk("b2b_xor_done", {31'd0, bus.done}, 32'd1);
    chk("b2b_xor_res",  bus.result, 32'h0FF00FF0);
    chk("b2b_xor_wen",  {31'd0, bus.write_en}, 32'd1);
    issue(4'b0011, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0, 32'h0, 5'd11, 1'b1);
    tick();
    chk("b2b_sltu_done", {31'd0, bus.done}, 32'd1);
    chk("b2b_sltu_res",  bus.result, 32'd1);
    chk("b2b_sltu_rd",   {27'd0, bus.rd_out}, 32'd11);

    // SLT signed: -1 < 1
    issue(4'b0010, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 5'd12, 1'b1);
    tick();
    chk("slt_res", bus.result, 32'd1);

    // undefined ALU code: zero result, no write
    issue(4'b1001, 1'b0, 1'b0, 32'hAAAA5555, 32'd3, 32'h0, 32'h0, 5'd13, 1'b1);
    tick();
    bus.start = 1'b0;
    chk("undef_done", {31'd0, bus.done}, 32'd1);
    chk("undef_res",  bus.result, 32'd0);
    chk("undef_wen",  {31'd0, bus.write_en}, 32'd0);
    tick();
    chk("idle_done", {31'd0, bus.done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
# exec_unit

Multicycle execute stage for the RV32I core. It sits directly downstream of the register file and consumes its two read operands plus the decoded immediate and PC. It computes RV32I ALU results or branch decisions and presents `rd`, result and write enable back to the register file's write port. Shifts run on an iterative one-bit-per-cycle shifter; all other operations complete in one cycle.

## Interface
- `WIDTH`, 32: datapath width; only 32 is supported.
- `Clk`  in  1  clock; all state updates on rising edge.
- `Rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  launch an operation; accepted only when `busy`=0.
- `op`  in  4  {funct7[5], funct3} for ALU ops; funct3 in `op[2:0]` for branches.
- `is_branch`  in  1  operation is a conditional branch.
- `use_imm`  in  1  B operand is `imm` instead of `Op_B` (ALU ops only).
- `Op_A`  in  WIDTH  register-file read port A.
- `Op_B`  in  WIDTH  register-file read port B.
- `imm`  in  WIDTH  sign-extended immediate.
- `pc`  in  WIDTH  PC of the instruction.
- `rd_in`  in  5  destination register.
- `wb_en_in`  in  1  instruction writes `rd`.
- `busy`  out  1  shifter iterating; `start` is ignored.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  WIDTH  ALU result, or branch target for branches.
- `branch_taken`  out  1  branch condition true; valid with `done`.
- `rd_out`  out  5  latched `rd_in`.
- `write_en`  out  1  `done` AND latched `wb_en_in` AND NOT branch AND latched `rd_in`≠0.

## Operation
- States:
  - IDLE: waits for `start`.
  - SHIFT: shifter iterating.
  - DONE: one-cycle result presentation.
- Capture: `start` is accepted in IDLE or DONE, i.e. whenever `busy`=0.
  - On acceptance, latch A=`Op_A`; B=`use_imm`?`imm`:`Op_B`; `op`, `is_branch`, `rd_in`, `wb_en_in`, `pc`, `imm`.
- ALU ops (`is_branch`=0):
  - 0000 ADD, 1000 SUB, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0110 OR, 0111 AND.
  - Other codes: result = 0, `write_en` = 0.
  - Arithmetic is modulo 2^32; overflow is ignored. SLT/SLTU produce 0 or 1.
- Shifts: 0001 SLL, 0101 SRL, 1101 SRA.
  - Shift amount = B[4:0]; B[31:5] are ignored.
  - Amount 0: result = A; go directly to DONE.
  - Otherwise enter SHIFT with count = amount. Each cycle shifts 1 bit (SRA replicates bit 31) and decrements count; at count 1 → DONE.
- Branches (`is_branch`=1):
  - Compare A vs `Op_B` (`use_imm` is ignored) using `op[2:0]`: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - 010/011 are not taken.
  - `result` = `pc`+`imm` for any funct3.
- DONE lasts one cycle, then IDLE unless a new `start` is accepted.
- `result`, `branch_taken` and `rd_out` hold their values until the next completion.
- `start` while `busy`=1 is dropped with no side effect.

## Timing
- Reset (`Rst`=0 at a rising edge):
  - State → IDLE. `busy`, `done`, `write_en`, `branch_taken` = 0; `result` = 0; `rd_out` = 0.
  - An in-flight shift is aborted with no `done`.
  - `Rst` has priority over `start`.
- `start` accepted at edge T:
  - Non-shift op or shift by 0: `done` is high in cycle T+1 (latency 1).
  - Shift by n≥1: `busy` is high in cycles T+1 … T+n; `done` is high in cycle T+1+n.
- `write_en` is coincident with `done` and high for exactly one cycle.
  - This lets the register file write on the falling edge of that cycle.
- Back-to-back: `start` in the DONE cycle is accepted, so there is a completion every cycle for non-shift ops.
- Operands are sampled only at the accepting edge; later changes on `Op_A`/`Op_B` do not affect the operation.

## Test plan
- Reset mid-SLL: deassert reset, start SLL A=1 B=31, assert `Rst`=0 at cycle 5 → no `done` ever; all outputs 0 the next cycle.
- ADD 0x7FFFFFFF+1, rd=5, wb_en=1 → `done` and `write_en` high at T+1, `result`=0x80000000, `rd_out`=5. SUB 0−1 → 0xFFFFFFFF.
- SRA A=0x80000000 B=0x00000024 (amount 4) → `busy` high 4 cycles, `done` at T+5, `result`=0xF8000000. SLL by 0 → `done` at T+1, `result`=A.
- Start issued while `busy` → ignored; the original shift's result and timing are unchanged.
- BLT A=0xFFFFFFFF B=1 → taken. BLTU with the same operands → not taken. `pc`=0x100, `imm`=0xFFFFFFF0 → `result`=0xF0, `write_en`=0.
- Back-to-back ADD, XOR, SLTU starts in consecutive cycles → three consecutive `done` pulses with the correct results; rd=0 → `write_en`=0.
